cu_int_seq: RTL and testbench



---
 rtl/cu_int_seq.sv | 141 ++++++++++++++
 tb/tb_cu_int_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_int_seq.sv
// Interrupt/BRK sequencer for the NES CPU control unit: runs the 7-cycle 6502
// push-and-vector sequence at an instruction boundary and releases the serviced flag.
module cu_int_seq (
   input  logic        CU_Clk,
   input  logic        CU_bRst,
   input  logic        CU_bNMI_Flg,
   input  logic        CU_bIRQ_Flg,
   output logic        CU_bNMI_SD,
   output logic        CU_bIRQ_SD,
   input  logic        CU_InstDone,
   input  logic        CU_BrkReq,
   input  logic        CU_IFlag,
   input  logic [15:0] CU_PC,
   input  logic [7:0]  CU_P,
   input  logic [7:0]  CU_SP,
   input  logic [7:0]  CU_Din,
   output logic [15:0] CU_Addr,
   output logic [7:0]  CU_Dout,
   output logic        CU_RW,
   output logic        CU_SPDec,
   output logic        CU_PCLoad,
   output logic [15:0] CU_PCNew,
   output logic        CU_SetI,
   output logic        CU_Busy,
   output logic [2:0]  CU_State
);

   typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4, S5, S6} state_t;
   typedef enum logic [1:0] {K_NMI, K_IRQ, K_BRK} kind_t;

   state_t      state;
   kind_t       kind;
   logic        bBit;
   logic [15:0] pcLat;
   logic [7:0]  pLat;
   logic [7:0]  vecLo;
   logic        nmiReq;
   logic        irqReq;
   logic        anyReq;
   logic [15:0] pushPc;
   logic [15:0] vecBase;

   assign nmiReq  = ~CU_bNMI_Flg;
   assign irqReq  = ~CU_bIRQ_Flg & ~CU_IFlag;
   assign anyReq  = nmiReq | irqReq | CU_BrkReq;
   assign pushPc  = bBit ? pcLat + 16'd2 : pcLat;
   assign vecBase = (kind == K_NMI) ? 16'hFFFA : 16'hFFFE;

   always_ff @(posedge CU_Clk or negedge CU_bRst) begin
      if (!CU_bRst) begin
         state <= IDLE;
         kind  <= K_NMI;
         bBit  <= 1'b0;
         pcLat <= 16'h0000;
         pLat  <= 8'h00;
         vecLo <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (CU_InstDone && anyReq) begin
                  state <= S0;
                  pcLat <= CU_PC;
                  pLat  <= CU_P;
                  if (nmiReq) begin
                     kind <= K_NMI;
                     bBit <= 1'b0;
                  end else if (irqReq) begin
                     kind <= K_IRQ;
                     bBit <= 1'b0;
                  end else begin
                     kind <= K_BRK;
                     bBit <= 1'b1;
                  end
               end
            end
            S0: state <= S1;
            S1: state <= S2;
            S2: state <= S3;
            S3: state <= S4;
            S4: state <= S5;
            S5: begin
               state <= S6;
               vecLo <= CU_Din;
            end
            S6: state <= IDLE;
            default: state <= IDLE;
         endcase
         // NMI arriving before the vector fetch steals the sequence; B stays as chosen.
         if ((state == S0 || state == S1 || state == S2 || state == S3 || state == S4) && nmiReq)
            kind <= K_NMI;
      end
   end

   always_comb begin
      CU_Addr    = 16'h0000;
      CU_RW      = 1'b1;
      CU_Dout    = 8'h00;
      CU_SPDec   = 1'b0;
      CU_PCLoad  = 1'b0;
      CU_PCNew   = 16'h0000;
      CU_SetI    = 1'b0;
      CU_bNMI_SD = 1'b1;
      CU_bIRQ_SD = 1'b1;
      case (state)
         S0: CU_Addr = pcLat;
         S1: CU_Addr = bBit ? pcLat + 16'd1 : pcLat;
         S2: begin
            CU_Addr  = {8'h01, CU_SP};
            CU_RW    = 1'b0;
            CU_Dout  = pushPc[15:8];
            CU_SPDec = 1'b1;
         end
         S3: begin
            CU_Addr  = {8'h01, CU_SP};
            CU_RW    = 1'b0;
            CU_Dout  = pushPc[7:0];
            CU_SPDec = 1'b1;
         end
         S4: begin
            CU_Addr  = {8'h01, CU_SP};
            CU_RW    = 1'b0;
            CU_Dout  = {pLat[7:6], 1'b1, bBit, pLat[3:0]};
            CU_SPDec = 1'b1;
         end
         S5: CU_Addr = vecBase;
         S6: begin
            CU_Addr    = {vecBase[15:1], 1'b1};
            CU_PCLoad  = 1'b1;
            CU_PCNew   = {CU_Din, vecLo};
            CU_SetI    = 1'b1;
            CU_bNMI_SD = ~(kind == K_NMI);
            CU_bIRQ_SD = ~(kind == K_IRQ);
         end
         default: ;
      endcase
   end

   assign CU_Busy  = (state != IDLE);
   assign CU_State = state;

endmodule

// File: tb/tb_cu_int_seq.sv
// Directed and random bench for cu_int_seq: expected bus cycles are queued at each
// boundary and compared cycle by cycle while the sequencer is busy.
module tb_cu_int_seq;

   localparam logic [1:0] K_NMI = 2'd0;
   localparam logic [1:0] K_IRQ = 2'd1;
   localparam logic [1:0] K_BRK = 2'd2;
   localparam int W = 46;

   logic        CU_Clk = 1'b0;
   logic        CU_bRst = 1'b0;
   logic        CU_bNMI_Flg = 1'b1;
   logic        CU_bIRQ_Flg = 1'b1;
   logic        CU_bNMI_SD;
   logic        CU_bIRQ_SD;
   logic        CU_InstDone = 1'b0;
   logic        CU_BrkReq = 1'b0;
   logic        CU_IFlag = 1'b0;
   logic [15:0] CU_PC = 16'h0000;
   logic [7:0]  CU_P = 8'h00;
   logic [7:0]  CU_SP;
   logic [7:0]  CU_Din;
   logic [15:0] CU_Addr;
   logic [7:0]  CU_Dout;
   logic        CU_RW;
   logic        CU_SPDec;
   logic        CU_PCLoad;
   logic [15:0] CU_PCNew;
   logic        CU_SetI;
   logic        CU_Busy;
   logic [2:0]  CU_State;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs;
   logic [W-1:0] expw;
   logic [W-1:0] idle_w;
   logic [7:0]   sp = 8'hFD;

   cu_int_seq dut (
      .CU_Clk(CU_Clk), .CU_bRst(CU_bRst),
      .CU_bNMI_Flg(CU_bNMI_Flg), .CU_bIRQ_Flg(CU_bIRQ_Flg),
      .CU_bNMI_SD(CU_bNMI_SD), .CU_bIRQ_SD(CU_bIRQ_SD),
      .CU_InstDone(CU_InstDone), .CU_BrkReq(CU_BrkReq), .CU_IFlag(CU_IFlag),
      .CU_PC(CU_PC), .CU_P(CU_P), .CU_SP(CU_SP), .CU_Din(CU_Din),
      .CU_Addr(CU_Addr), .CU_Dout(CU_Dout), .CU_RW(CU_RW), .CU_SPDec(CU_SPDec),
      .CU_PCLoad(CU_PCLoad), .CU_PCNew(CU_PCNew), .CU_SetI(CU_SetI),
      .CU_Busy(CU_Busy), .CU_State(CU_State)
   );

   // clock / reset-independent environment: memory and stack pointer owner
   always #5 CU_Clk = ~CU_Clk;

   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      case (a)
         16'hFFFA: mem_rd = 8'h00;
         16'hFFFB: mem_rd = 8'hC0;
         16'hFFFE: mem_rd = 8'h34;
         16'hFFFF: mem_rd = 8'hE0;
         default:  mem_rd = a[7:0] ^ a[15:8];
      endcase
   endfunction

   assign CU_Din = mem_rd(CU_Addr);
   always @(posedge CU_Clk) if (CU_SPDec) sp <= sp - 8'd1;
   assign CU_SP = sp;

   function automatic logic [W-1:0] mk(input logic [15:0] addr, input logic rw, input logic [7:0] dout,
                                       input logic spdec, input logic pcload, input logic [15:0] pcnew,
                                       input logic seti, input logic nsd, input logic isd);
      mk = {addr, rw, dout, spdec, pcload, pcnew, seti, nsd, isd};
   endfunction

   assign obs = {CU_Addr, CU_RW, CU_Dout, CU_SPDec, CU_PCLoad, CU_PCNew, CU_SetI, CU_bNMI_SD, CU_bIRQ_SD};
   assign idle_w = mk(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

   // expected model of one full sequence; hij means an NMI will steal it before S5
   task automatic push_seq(input logic [1:0] kind, input logic is_brk, input logic hij,
                           input logic [15:0] pc, input logic [7:0] p);
      logic [15:0] ppc, vec, vec1, a1;
      logic [1:0]  fk;
      logic [7:0]  s;
      s    = sp;
      ppc  = is_brk ? pc + 16'd2 : pc;
      a1   = is_brk ? pc + 16'd1 : pc;
      fk   = hij ? K_NMI : kind;
      vec  = (fk == K_NMI) ? 16'hFFFA : 16'hFFFE;
      vec1 = vec + 16'd1;
      exp_q.push_back(mk(pc, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk(a1, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk({8'h01, s}, 1'b0, ppc[15:8], 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk({8'h01, s - 8'd1}, 1'b0, ppc[7:0], 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk({8'h01, s - 8'd2}, 1'b0, {p[7:6], 1'b1, is_brk, p[3:0]}, 1'b1, 1'b0,
                         16'h0000, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk(vec, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk(vec1, 1'b1, 8'h00, 1'b0, 1'b1, {mem_rd(vec1), mem_rd(vec)}, 1'b1,
                         fk != K_NMI, fk != K_IRQ));
   endtask

   // drive one instruction boundary and queue what it should trigger
   task automatic boundary(input logic nmi_f, input logic irq_f, input logic iflag, input logic brk,
                           input logic [15:0] pc, input logic [7:0] p, input logic hij);
      @(posedge CU_Clk); #1;
      CU_bNMI_Flg = nmi_f;
      CU_bIRQ_Flg = irq_f;
      CU_IFlag    = iflag;
      CU_BrkReq   = brk;
      CU_PC       = pc;
      CU_P        = p;
      CU_InstDone = 1'b1;
      if (!nmi_f)                push_seq(K_NMI, 1'b0, 1'b0, pc, p);
      else if (!irq_f && !iflag) push_seq(K_IRQ, 1'b0, hij, pc, p);
      else if (brk)              push_seq(K_BRK, 1'b1, hij, pc, p);
      @(posedge CU_Clk); #1;
      CU_InstDone = 1'b0;
      CU_BrkReq   = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge CU_Clk);
         n++;
      end while (CU_Busy && n < 20);
      checks++;
      assert (CU_Busy === 1'b0) else begin
         errors++;
         $error("FAIL %s_idle_timeout busy=%b required=0", tag, CU_Busy);
      end
   endtask

   task automatic wait_pcload(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge CU_Clk);
         n++;
      end while (!CU_PCLoad && n < 20);
      checks++;
      assert (CU_PCLoad === 1'b1) else begin
         errors++;
         $error("FAIL %s_pcload_timeout pcload=%b required=1", tag, CU_PCLoad);
      end
   endtask

   // scoreboard: every busy cycle pops one expected bus word; idle cycles must look idle
   always @(negedge CU_Clk) begin
      if (CU_Busy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL seq_extra_cycle state=%0d required=idle", CU_State);
         end else begin
            expw = exp_q.pop_front();
            assert (obs === expw) else begin
               errors++;
               $error("FAIL seq_cycle state=%0d observed=%h expected=%h", CU_State, obs, expw);
            end
         end
      end else begin
         checks++;
         assert (obs === idle_w) else begin
            errors++;
            $error("FAIL idle_outputs observed=%h expected=%h", obs, idle_w);
         end
         if (!CU_InstDone) begin
            checks++;
            assert (exp_q.size() == 0) else begin
               errors++;
               $error("FAIL seq_short pending=%0d required=0", exp_q.size());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  sel;
      logic [15:0] rpc;
      logic [7:0]  rp;
      int          left;

      // reset state
      #12;
      checks++;
      assert (obs === idle_w && CU_Busy === 1'b0 && CU_State === 3'd0) else begin
         errors++;
         $error("FAIL reset_state observed=%h/%b/%0d expected=%h/0/0", obs, CU_Busy, CU_State, idle_w);
      end
      @(posedge CU_Clk); #1;
      CU_bRst = 1'b1;

      // NMI at boundary
      boundary(1'b0, 1'b1, 1'b0, 1'b0, 16'h8123, 8'h24, 1'b0);
      wait_idle("nmi");
      CU_bNMI_Flg = 1'b1;

      // IRQ masked, then unmasked
      boundary(1'b1, 1'b0, 1'b1, 1'b0, 16'h4000, 8'h04, 1'b0);
      repeat (2) @(negedge CU_Clk);
      checks++;
      assert (CU_Busy === 1'b0) else begin
         errors++;
         $error("FAIL irq_masked busy=%b required=0", CU_Busy);
      end
      boundary(1'b1, 1'b0, 1'b0, 1'b0, 16'h4002, 8'h20, 1'b0);
      wait_idle("irq");
      CU_bIRQ_Flg = 1'b1;

      // BRK with PC wrap
      boundary(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 8'hC3, 1'b0);
      wait_idle("brk");

      // NMI steals an IRQ sequence in S3; IRQ then serviced at next boundary
      boundary(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h61, 1'b1);
      repeat (3) @(posedge CU_Clk);
      #1;
      CU_bNMI_Flg = 1'b0;
      wait_pcload("hijack");
      @(posedge CU_Clk); #1;
      CU_bNMI_Flg = 1'b1;
      boundary(1'b1, 1'b0, 1'b0, 1'b0, 16'h2345, 8'h61, 1'b0);
      wait_idle("irq_after_hijack");
      CU_bIRQ_Flg = 1'b1;

      // simultaneous NMI+IRQ, IRQ follows with zero gap
      boundary(1'b0, 1'b0, 1'b0, 1'b0, 16'h5000, 8'h80, 1'b0);
      wait_pcload("b2b_nmi");
      @(posedge CU_Clk); #1;
      CU_bNMI_Flg = 1'b1;
      CU_PC       = 16'h5000;
      CU_P        = 8'h81;
      CU_InstDone = 1'b1;
      push_seq(K_IRQ, 1'b0, 1'b0, 16'h5000, 8'h81);
      @(posedge CU_Clk); #1;
      CU_InstDone = 1'b0;
      checks++;
      assert (CU_State === 3'd1 && CU_Busy === 1'b1) else begin
         errors++;
         $error("FAIL b2b_restart state=%0d busy=%b required=1/1", CU_State, CU_Busy);
      end
      wait_idle("b2b_irq");
      CU_bIRQ_Flg = 1'b1;

      // reset asserted in S4
      boundary(1'b1, 1'b0, 1'b0, 1'b0, 16'h6789, 8'h00, 1'b0);
      repeat (4) @(posedge CU_Clk);
      #1;
      left = exp_q.size();
      checks++;
      assert (left == 3 && CU_State === 3'd5) else begin
         errors++;
         $error("FAIL reset_s4_position pending=%0d state=%0d required=3/5", left, CU_State);
      end
      CU_bRst = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      assert (obs === idle_w && CU_Busy === 1'b0 && CU_State === 3'd0) else begin
         errors++;
         $error("FAIL reset_async observed=%h/%b/%0d expected=%h/0/0", obs, CU_Busy, CU_State, idle_w);
      end
      repeat (3) @(posedge CU_Clk);
      #1;
      CU_bIRQ_Flg = 1'b1;
      CU_bRst = 1'b1;
      repeat (2) @(negedge CU_Clk);

      // random sequences
      for (int i = 0; i < 4; i++) begin
         sel = 2'($urandom_range(0, 2));
         rpc = 16'($urandom_range(0, 65535));
         rp  = 8'($urandom_range(0, 255));
         boundary(sel != 2'd0, sel != 2'd1, 1'b0, sel == 2'd2, rpc, rp, 1'b0);
         wait_idle("random");
         CU_bNMI_Flg = 1'b1;
         CU_bIRQ_Flg = 1'b1;
      end

      repeat (3) @(negedge CU_Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
